pe_row_sequencer: RTL and testbench
===================================

// Module: pe_row_sequencer
// PURPOSE
//  Drives one PE through a 64x64 nibble matrix-vector product.
//  - Per row: clear, stream 16 beats of 4 matrix nibbles paired with the matching SHA3 nibbles, drain, capture.
//  - Capture truncates the 14-bit row sum to 4 bits (sum>>10).
//  - Nibbles of rows 2k/2k+1 are packed into a byte and XORed with SHA3 byte k.
//  - Emits 32 bytes per job on a valid/ready stream; sits between the matrix ROM and the final SHA3 stage.
// PARAMETERS
//  WCOUNT  4   nibbles per PE beat (pe_m/pe_x width = 4*WCOUNT)
//  NNIB    64  nibbles per vector / rows per matrix; beats per row = NNIB/WCOUNT
//  PE_LAT  2   PE internal pipeline depth to flush before capture
//  SHIFT   10  right shift applied to the row sum before 4-bit truncation
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  start      in   1         job start pulse; x_vec sampled in the same cycle
//  x_vec      in   4*NNIB    SHA3 hash vector; nibble b = x_vec[4b+3:4b], byte k = x_vec[8k+7:8k]
//  m_valid    in   1         matrix beat valid
//  m_data     in   4*WCOUNT  matrix beat; row-major, beat b carries nibbles 4b..4b+3
//  m_ready    out  1         matrix beat accepted when m_valid&m_ready
//  pe_en      out  1         PE enable (registered)
//  pe_clr     out  1         PE clear (registered)
//  pe_m       out  4*WCOUNT  PE matrix operand (registered)
//  pe_x       out  4*WCOUNT  PE SHA3 operand (registered)
//  pe_out     in   14        PE accumulator
//  out_valid  out  1         product byte valid
//  out_data   out  8         {nib[2k],nib[2k+1]} ^ x_vec byte k
//  out_ready  in   1         downstream accept
//  busy       out  1         high from accepted start until done
//  done       out  1         one-cycle pulse after byte 31 is accepted
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0, including pe_m/pe_x, out_data, and the row/beat counters.
//  - Reset is honoured mid-job; a partial job is discarded with no output.
//  - IDLE: start latches x_vec, clears row=0 and moves to CLR. start while busy is ignored, and the latched x_vec is unchanged.
//  - CLR (1 cycle): pe_clr=1, pe_en=0, beat=0 -> FEED.
//  - FEED: m_ready=1.
//    - On accept: pe_m<=m_data, pe_x<=x_vec slice[beat], pe_en<=1, beat++.
//    - On no accept: pe_en<=0, and pe_m/pe_x hold their last value (stall-safe for the PE's free-running DSP stage).
//    - The accept with beat==NNIB/WCOUNT-1 moves to DRAIN.
//  - DRAIN: PE_LAT+1 cycles with pe_en=1, pe_m=pe_x=0 (zero terms flush the pipeline), m_ready=0 -> CAPT.
//  - CAPT (1 cycle): nib = pe_out[SHIFT+3:SHIFT].
//    - Even row: store as high nibble, row++ -> CLR.
//    - Odd row: form byte, XOR with x byte row>>1 -> EMIT.
//  - EMIT: out_valid=1, out_data stable until out_ready.
//    - On accept with row==NNIB-1: done=1 for one cycle, busy=0 -> IDLE.
//    - Otherwise: row++ -> CLR.
//  - Widths: max row sum 64*15*15=14400 < 2^14, so no overflow handling. out_valid and m_ready are never high together.
//  - Latency per row = 1 + 16 + PE_LAT+1 + 1 cycles, plus 1 EMIT cycle on odd rows with no stalls.
// CONFIGURATION
//  PE_SEQ_RAW_EN defined:
//    - Adds output raw_valid (1) and raw_sum (14).
//    - raw_valid pulses in each CAPT cycle; raw_sum = pe_out, unshifted.
//  PE_SEQ_RAW_EN undefined: the ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  - heavyhash_pkg: state enum (IDLE,CLR,FEED,DRAIN,CAPT,EMIT), NNIB, ROWS, BEATS, SHIFT constants.
//  - The PE is instantiated by the parent, not here. No sub-module; one FSM plus row/beat/drain counters.
// TESTING
//  1. M nibbles all 0xF, x_vec all 0xF -> sum 14400, nib 0xE, all 32 out_data = 0xEE^0xFF = 0x11.
//  2. M all 0x1, x all 0xF -> sum 960, nib 0, all out_data = 0xFF; busy falls, done pulses once.
//  3. Case 1 with m_valid toggling every other cycle -> identical bytes, exactly 16 pe_en beats per row before DRAIN.
//  4. out_ready low 10 cycles in EMIT -> out_data stable, m_ready=0, pe_en=0 throughout.
//  5. rst_n low mid-FEED of row 5 -> all outputs 0 immediately; a new start yields 32 correct bytes.
//  6. start pulsed with a new x_vec during a job -> ignored; output bytes match the first x_vec.

Source files
------------

// File: rtl/heavyhash_pkg.sv
// Shared constants and FSM state encoding for the HeavyHash PE row sequencer.
package heavyhash_pkg;
  localparam int NNIB   = 64;
  localparam int WCOUNT = 4;
  localparam int ROWS   = NNIB;
  localparam int BEATS  = NNIB / WCOUNT;
  localparam int PE_LAT = 2;
  localparam int SHIFT  = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_CAPT,
    S_EMIT
  } state_e;
endpackage

// File: rtl/pe_row_sequencer.sv
// Sequences one PE through a NNIB x NNIB nibble matrix-vector product, emitting packed bytes.
// Optional PE_SEQ_RAW_EN adds raw_valid/raw_sum debug outputs.
module pe_row_sequencer #(
  parameter int WCOUNT = heavyhash_pkg::WCOUNT,
  parameter int NNIB   = heavyhash_pkg::NNIB,
  parameter int PE_LAT = heavyhash_pkg::PE_LAT,
  parameter int SHIFT  = heavyhash_pkg::SHIFT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*NNIB-1:0]   x_vec,
  input  logic                m_valid,
  input  logic [4*WCOUNT-1:0] m_data,
  output logic                m_ready,
  output logic                pe_en,
  output logic                pe_clr,
  output logic [4*WCOUNT-1:0] pe_m,
  output logic [4*WCOUNT-1:0] pe_x,
  input  logic [13:0]         pe_out,
  output logic                out_valid,
  output logic [7:0]          out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
`ifdef PE_SEQ_RAW_EN
  ,
  output logic                raw_valid,
  output logic [13:0]         raw_sum
`endif
);
  import heavyhash_pkg::*;

  localparam int BW    = 4 * WCOUNT;
  localparam int XW    = 4 * NNIB;
  localparam int NBEAT = NNIB / WCOUNT;
  localparam int RW    = $clog2(NNIB);
  localparam int BTW   = $clog2(NBEAT);
  localparam int DW    = $clog2(PE_LAT + 2);

  localparam logic [RW-1:0]  ROW_LAST   = RW'(NNIB - 1);
  localparam logic [BTW-1:0] BEAT_LAST  = BTW'(NBEAT - 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(PE_LAT);

  state_e         state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [BTW-1:0] beat_q, beat_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [XW-1:0]  x_q, x_d;
  logic [3:0]     hi_q, hi_d;
  logic           pe_en_q, pe_en_d;
  logic           pe_clr_q, pe_clr_d;
  logic [BW-1:0]  pe_m_q, pe_m_d;
  logic [BW-1:0]  pe_x_q, pe_x_d;
  logic           m_ready_q, m_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [3:0] nib;
  logic       m_acc;
  logic       o_acc;

  assign nib   = pe_out[SHIFT+3:SHIFT];
  assign m_acc = m_valid & m_ready_q;
  assign o_acc = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    x_d         = x_q;
    hi_d        = hi_q;
    pe_en_d     = 1'b0;
    pe_clr_d    = 1'b0;
    pe_m_d      = pe_m_q;
    pe_x_d      = pe_x_q;
    m_ready_d   = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d      = x_vec;
          row_d    = '0;
          busy_d   = 1'b1;
          pe_clr_d = 1'b1;
          state_d  = S_CLR;
        end
      end
      S_CLR: begin
        beat_d    = '0;
        m_ready_d = 1'b1;
        state_d   = S_FEED;
      end
      S_FEED: begin
        m_ready_d = 1'b1;
        // operands hold on a stall; only pe_en drops
        if (m_acc) begin
          pe_m_d  = m_data;
          pe_x_d  = x_q[int'(beat_q)*BW +: BW];
          pe_en_d = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) begin
            m_ready_d = 1'b0;
            drain_d   = '0;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        pe_en_d = 1'b1;
        pe_m_d  = '0;
        pe_x_d  = '0;
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (!row_q[0]) begin
          hi_d     = nib;
          row_d    = row_q + 1'b1;
          pe_clr_d = 1'b1;
          state_d  = S_CLR;
        end else begin
          out_data_d  = {hi_q, nib} ^ x_q[int'(row_q[RW-1:1])*8 +: 8];
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (o_acc) begin
          if (row_q == ROW_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            row_d    = row_q + 1'b1;
            pe_clr_d = 1'b1;
            state_d  = S_CLR;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      beat_q      <= '0;
      drain_q     <= '0;
      x_q         <= '0;
      hi_q        <= '0;
      pe_en_q     <= 1'b0;
      pe_clr_q    <= 1'b0;
      pe_m_q      <= '0;
      pe_x_q      <= '0;
      m_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      x_q         <= x_d;
      hi_q        <= hi_d;
      pe_en_q     <= pe_en_d;
      pe_clr_q    <= pe_clr_d;
      pe_m_q      <= pe_m_d;
      pe_x_q      <= pe_x_d;
      m_ready_q   <= m_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign m_ready   = m_ready_q;
  assign pe_en     = pe_en_q;
  assign pe_clr    = pe_clr_q;
  assign pe_m      = pe_m_q;
  assign pe_x      = pe_x_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef PE_SEQ_RAW_EN
  logic raw_valid_q, raw_valid_d;

  assign raw_valid_d = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_valid_q <= 1'b0;
    end else begin
      raw_valid_q <= raw_valid_d;
    end
  end

  assign raw_valid = raw_valid_q;
  assign raw_sum   = pe_out;
`else
  logic unused_pe_out;
  assign unused_pe_out = ^{pe_out[13:SHIFT+4], pe_out[SHIFT-1:0]};
`endif

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Self-checking bench for pe_row_sequencer with an attached behavioural PE.
module tb_pe_row_sequencer;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] x_vec;
  logic         m_valid;
  logic [15:0]  m_data;
  logic         m_ready;
  logic         pe_en;
  logic         pe_clr;
  logic [15:0]  pe_m;
  logic [15:0]  pe_x;
  logic [13:0]  pe_out;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [3:0]   mat [64][64];
  logic [255:0] xv;

  pe_row_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_vec(x_vec),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .pe_en(pe_en), .pe_clr(pe_clr), .pe_m(pe_m), .pe_x(pe_x),
    .pe_out(pe_out), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE: registered operands, two pipeline stages, then accumulator
  function automatic int dot4(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(a[4*i +: 4]) * int'(b[4*i +: 4]);
    return s;
  endfunction

  int p1, p2, acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 0; p2 <= 0; acc <= 0;
    end else if (pe_clr) begin
      p1 <= 0; p2 <= 0; acc <= 0;
    end else begin
      p1  <= pe_en ? dot4(pe_m, pe_x) : 0;
      p2  <= p1;
      acc <= acc + p2;
    end
  end
  assign pe_out = acc[13:0];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int row_sum(input int r);
    int s;
    s = 0;
    for (int j = 0; j < 64; j++) s += int'(mat[r][j]) * int'(xv[4*j +: 4]);
    return s;
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    logic [3:0] hi, lo;
    hi = 4'((row_sum(2*k) >> 10) & 15);
    lo = 4'((row_sum(2*k+1) >> 10) & 15);
    return {hi, lo} ^ xv[8*k +: 8];
  endfunction

  function automatic logic [15:0] beat_word(input int idx);
    logic [15:0] w;
    w = '0;
    if (idx < 1024)
      for (int i = 0; i < 4; i++) w[4*i +: 4] = mat[idx/16][4*(idx%16)+i];
    return w;
  endfunction

  function automatic logic [45:0] outs_all();
    return {m_ready, pe_en, pe_clr, pe_m, pe_x, out_valid, out_data, busy, done};
  endfunction

  task automatic fill(input bit rnd, input logic [3:0] mv, input logic [3:0] xvv);
    for (int r = 0; r < 64; r++)
      for (int j = 0; j < 64; j++)
        mat[r][j] = rnd ? 4'($urandom_range(0, 15)) : mv;
    for (int j = 0; j < 64; j++)
      xv[4*j +: 4] = rnd ? 4'($urandom_range(0, 15)) : xvv;
  endtask

  // vmode: 0 always valid, 1 every other cycle, 2 random
  // rmode: 0 always ready, 1 ten-cycle stall per byte, 2 random
  task automatic run_job(input int vmode, input int rmode, input int abort_idx,
                         input int poke_cyc, input int lit, input int exp_cyc);
    int idx, nb, cyc, stall, en_cnt;
    bit m_acc, o_acc, fin, hold, aborted, mv;
    logic [7:0] held;
    idx = 0; nb = 0; cyc = 0; stall = 0; en_cnt = 0;
    m_acc = 0; o_acc = 0; fin = 0; hold = 0; aborted = 0; held = '0;
    @(negedge clk);
    start = 1'b1;
    x_vec = xv;
    while (!fin && !aborted && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (m_acc) idx++;
      if (o_acc) begin nb++; stall = 0; end
      if (abort_idx >= 0 && idx == abort_idx) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", outs_all(), 0);
        chk("rst_mid_bytes", nb, 2);
        m_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
      end else begin
        chk("valid_ready_excl", out_valid & m_ready, 0);
        if (pe_clr) begin
          if (en_cnt != 0) chk("en_beats_row", en_cnt, 19);
          en_cnt = 0;
        end
        if (pe_en) en_cnt++;
        if (out_valid) chk("pe_en_in_emit", pe_en, 0);
        if (hold) begin
          chk("hold_data", out_data, held);
          chk("hold_valid", out_valid, 1);
        end
        if (done) begin
          fin = 1;
          chk("busy_at_done", busy, 0);
          chk("bytes_at_done", nb, 32);
          chk("en_beats_last", en_cnt, 19);
          if (exp_cyc > 0) chk("done_latency", cyc, exp_cyc);
        end else begin
          chk("busy_in_job", busy, 1);
        end
        if (cyc == poke_cyc) begin
          start = 1'b1;
          x_vec = ~xv;
        end
        case (vmode)
          0: mv = 1'b1;
          1: mv = (cyc % 2) == 0;
          default: mv = 1'($urandom_range(0, 1));
        endcase
        m_valid = mv && (idx < 1024);
        m_data  = beat_word(idx);
        case (rmode)
          0: out_ready = 1'b1;
          1: out_ready = stall >= 10;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid && !out_ready) stall++;
        m_acc = m_valid && m_ready;
        o_acc = out_valid && out_ready;
        if (o_acc) begin
          chk("byte", out_data, exp_byte(nb));
          if (lit >= 0) chk("byte_lit", out_data, lit);
        end
        hold = out_valid && !out_ready;
        held = out_data;
      end
    end
    m_valid = 1'b0;
    out_ready = 1'b0;
    start = 1'b0;
    if (!fin && !aborted) chk("job_timeout", cyc, -1);
    if (fin) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        chk("busy_after_done", busy, 0);
      end
    end
    if (aborted) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("silent_after_abort", {out_valid, busy}, 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; x_vec = '0; m_valid = 1'b0;
    m_data = '0; out_ready = 1'b0;
    #3;
    chk("reset_outputs", outs_all(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", outs_all(), 0);

    fill(0, 4'hF, 4'hF);
    chk("model_pin_sum_f", row_sum(0), 14400);
    chk("model_pin_byte_f", exp_byte(0), 8'h11);
    run_job(0, 0, -1, -1, 8'h11, 1377);

    fill(0, 4'h1, 4'hF);
    chk("model_pin_sum_1", row_sum(7), 960);
    chk("model_pin_byte_1", exp_byte(5), 8'hFF);
    run_job(0, 0, -1, -1, 8'hFF, 1377);

    fill(0, 4'hF, 4'hF);
    run_job(1, 0, -1, -1, 8'h11, 0);

    fill(1, 4'h0, 4'h0);
    run_job(0, 1, -1, -1, -1, 0);

    fill(1, 4'h0, 4'h0);
    run_job(0, 0, 5*16+7, -1, -1, 0);
    fill(1, 4'h0, 4'h0);
    run_job(2, 2, -1, -1, -1, 0);

    fill(1, 4'h0, 4'h0);
    run_job(2, 0, -1, 200, -1, 0);

    fill(1, 4'h0, 4'h0);
    run_job(2, 2, -1, 700, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
